// File: rtl/win_sprite_pkg.sv
// Shared layout constants for the packed 4-bit win-banner sprite.
// Both the loader (writer) and the palette lookup (reader) import this package.
package win_sprite_pkg;
  localparam int IMG_W_DEF    = 266;
  localparam int IMG_H_DEF    = 64;
  localparam int TOTAL        = IMG_W_DEF * IMG_H_DEF;
  localparam int NIB_W        = 4;
  localparam int PIX_PER_WORD = 8;
  localparam int LANE_W       = $clog2(PIX_PER_WORD);
  localparam int WORD_W       = NIB_W * PIX_PER_WORD;
  localparam int NWORDS       = (TOTAL + PIX_PER_WORD - 1) / PIX_PER_WORD;

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} ld_state_e;
endpackage

// File: rtl/win_sprite_loader_nibble_packer.sv
// Eight-lane nibble pack register; pixel k of a word lands in bits [4k+3:4k].
// 'word' is the register with the incoming nibble already merged, so a write can issue on the accepting edge.
module nibble_packer
  import win_sprite_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              clr,
  input  logic              wr_en,
  input  logic              word_done,
  input  logic [LANE_W-1:0] lane,
  input  logic [NIB_W-1:0]  din,
  output logic [WORD_W-1:0] word,
  output logic              lane_full
);
  logic [PIX_PER_WORD-1:0][NIB_W-1:0] pack_q, pack_d, merged;

  always_comb begin
    merged       = pack_q;
    merged[lane] = din;
    pack_d       = pack_q;
    if (clr)        pack_d = '0;
    else if (wr_en) pack_d = word_done ? '0 : merged;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) pack_q <= '0;
    else          pack_q <= pack_d;
  end

  assign word      = merged;
  assign lane_full = (lane == LANE_W'(PIX_PER_WORD - 1));
endmodule

// File: rtl/win_sprite_loader.sv
// Writer side of the win-sprite BRAM: packs a serial 4-bit pixel stream into 32-bit words
// and writes them one cycle after the accept that completes each word.
module win_sprite_loader
  import win_sprite_pkg::*;
#(
  parameter int                IMG_W     = IMG_W_DEF,
  parameter int                IMG_H     = IMG_H_DEF,
  parameter int                ADDR_W    = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              start,
  input  logic              pix_valid,
  input  logic [NIB_W-1:0]  pix_data,
  input  logic              pix_last,
  output logic              pix_ready,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [WORD_W-1:0] bram_wdata,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam int TOT   = IMG_W * IMG_H;
  localparam int CNT_W = $clog2(TOT + 1);

  ld_state_e         state_q, state_d;
  logic [CNT_W-1:0]  n_q, n_d;
  logic              err_q, err_d, we_q, we_d, done_q, done_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d, word;
  logic              accept, is_final, lane_full, word_done, pack_clr;

  assign pix_ready = (state_q == LOAD);
  assign accept    = pix_valid && pix_ready;
  assign is_final  = (n_q == CNT_W'(TOT - 1));
  assign word_done = lane_full || pix_last || is_final;

  nibble_packer u_pack (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .clr      (pack_clr),
    .wr_en    (accept),
    .word_done(word_done),
    .lane     (n_q[LANE_W-1:0]),
    .din      (pix_data),
    .word     (word),
    .lane_full(lane_full)
  );

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    err_d    = err_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    done_d   = 1'b0;
    pack_clr = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d  = LOAD;
          n_d      = '0;
          err_d    = 1'b0;
          pack_clr = 1'b0 | 1'b1;
        end
      end
      LOAD: begin
        if (accept) begin
          n_d = n_q + CNT_W'(1);
          if (word_done) begin
            we_d    = 1'b1;
            addr_d  = BASE_ADDR + ADDR_W'(n_q >> LANE_W);
            wdata_d = word;
          end
          // Either terminator ends the load; a mismatch between them is a length error.
          if (pix_last || is_final) begin
            state_d = FLUSH;
            err_d   = pix_last ^ is_final;
          end
        end
      end
      FLUSH: begin
        state_d = DONE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      n_q     <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= BASE_ADDR;
      wdata_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      err_q   <= err_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
    end
  end

  assign bram_we    = we_q;
  assign bram_addr  = addr_q;
  assign bram_wdata = wdata_q;
  assign busy       = (state_q == LOAD) || (state_q == FLUSH);
  assign done       = done_q;
  assign err        = err_q;
endmodule

// File: doc/win_sprite_loader.md
Name: win_sprite_loader

Overview:
- Writer side of the packed 4-bit win-banner sprite memory.
- Accepts a serial stream of 4-bit palette indices, packs 8 per 32-bit word, and writes the words into the sprite BRAM.
- Pixel k of a word sits in bits [4k+3:4k]. Word address = linear pixel index / 8, where linear index = x + y*IMG_W. This is the layout the palette lookup decodes.
- Sits between the MicroBlaze/AXI-fed pixel FIFO and the win-sprite BRAM write port.

Parameters:
- IMG_W, 266, sprite width in pixels.
- IMG_H, 64, sprite height in pixels.
- ADDR_W, 12, BRAM word-address width (must hold BASE_ADDR + ceil(IMG_W*IMG_H/8) - 1).
- BASE_ADDR, 0, first word address written.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; begins a load (ignored unless IDLE or DONE).
- pix_valid  input  1  pixel present on pix_data.
- pix_data  input  4  palette index.
- pix_last  input  1  qualifies final pixel of the stream.
- pix_ready  output  1  loader accepts pixel this cycle.
- bram_we  output  1  one-cycle write strobe.
- bram_addr  output  ADDR_W  word address.
- bram_wdata  output  32  packed word.
- busy  output  1  high in LOAD or FLUSH.
- done  output  1  one-cycle pulse on completion.
- err  output  1  sticky stream-length mismatch flag, cleared by start.

Behaviour:
- Reset (async, Reset_n=0): state IDLE; pix_ready, bram_we, busy, done, err = 0; bram_addr = BASE_ADDR; bram_wdata = 0; pixel counter = 0; pack register = 0. Reset mid-load aborts with no further writes.
- TOTAL = IMG_W*IMG_H = 17024 by default. NWORDS = ceil(TOTAL/8) = 2128. Pixel counter is 15 bits; the word index is counter[14:3].
- States:
  - IDLE: pix_ready=0. start → LOAD; clears counter, pack register, err.
  - LOAD: pix_ready=1. A pixel is accepted when pix_valid && pix_ready. On accept, pix_data is written into pack[4*(n%8)+:4], then n increments.
  - Word complete when n%8==7, pix_last is set, or n==TOTAL-1. The next cycle then has:
    - bram_we=1
    - bram_addr = BASE_ADDR + n/8
    - bram_wdata = packed word, with unwritten nibbles zero.
    - Pack register cleared for the next word.
  - Write latency: exactly 1 cycle after the accepting edge. Accepts may continue back-to-back, so 8 consecutive accepts give one write per 8 cycles. No BRAM back-pressure.
  - Accepting pix_last or pixel TOTAL-1 → FLUSH.
  - FLUSH: pix_ready=0. The final write issues this cycle → DONE.
  - DONE: done pulses for one cycle on entry, then the state holds; busy=0. start → LOAD (reload).
- Length checking:
  - pix_last before pixel TOTAL-1: err=1; partial word written zero-padded; remaining words not written.
  - Pixel TOTAL-1 accepted without pix_last: err=1; load still completes normally.
  - pix_last on pixel TOTAL-1 exactly: err stays 0.
- start asserted during LOAD/FLUSH is ignored.
- pix_valid while pix_ready=0 is not consumed; the upstream source holds it.
- bram_we is never high in IDLE or DONE except the FLUSH→DONE edge write already described.

Decomposition:
- Package win_sprite_pkg:
  - IMG_W/IMG_H defaults, TOTAL, NWORDS, nibble width 4, pixels-per-word 8.
  - Loader state enum {IDLE, LOAD, FLUSH, DONE}.
  - Shared with the palette/address-generation side so both agree on the layout.
- Optional single sub-module nibble_packer (8×4-bit pack register, lane select, word-complete flag); FSM and counters stay in the top.

Test Plan:
- Reset: hold Reset_n=0 with pix_valid=1 → pix_ready=0, bram_we=0, bram_addr=0, done=0, err=0. Release, no start → no writes for 100 cycles.
- Single word: start, stream nibbles 1,2,...,8 back-to-back → exactly one write, addr=0, wdata=32'h87654321, one cycle after the 8th accept.
- Full image: start, stream 17024 pixels (value = index mod 16) with pix_last on the final pixel → 2128 writes at addr 0..2127:
  - word k = 32'hFEDCBA98 for odd k, 32'h76543210 for even k;
  - single done pulse; err=0; reading back via palette index reproduces the pattern.
- Early last: pixels 0xA,0xB,0xC with pix_last on 0xC → one write, addr=0, wdata=32'h00000CBA; done pulses; err=1.
- Throttled source: random pix_valid gaps (~50% duty) over 64 pixels → same 8 words as gap-free run; no write on non-accept cycles.
- Abort/restart: assert Reset_n=0 after 20 pixels → outputs reset immediately, no write for the partial word. Then start, send 8 pixels → write at addr=0.
